// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-transaction memory controller port between the
// instruction fetcher (IF) and the load/store executor (LS).
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   rdy               global ready; 0 freezes every register
//   drop_flag         flush: aborts outstanding fetches/loads, blocks new ones
//   if_ena/if_pc      level-held fetch request and address
//   if_ok/if_inst     one-cycle fetch completion pulse and instruction
//   ls_ena/ls_wr/ls_size/ls_addr/ls_wdata   level-held load/store request
//   ls_ok/ls_rdata    one-cycle load/store completion pulse and load data
//   mc_ena            one-cycle issue pulse to the memory controller
//   mc_wr/mc_size/mc_addr/mc_wdata   issued command, stable while busy
//   mc_drop           one-cycle abort pulse to the controller
//   mc_ok/mc_rdata    controller completion pulse and read data
//   err_timeout       sticky watchdog flag
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        drop_flag,
    input  logic        if_ena,
    input  logic [31:0] if_pc,
    output logic        if_ok,
    output logic [31:0] if_inst,
    input  logic        ls_ena,
    input  logic        ls_wr,
    input  logic [2:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ok,
    output logic [31:0] ls_rdata,
    output logic        mc_ena,
    output logic        mc_wr,
    output logic [2:0]  mc_size,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_wdata,
    output logic        mc_drop,
    input  logic        mc_ok,
    input  logic [31:0] mc_rdata,
    output logic        err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      starve_cnt;
    logic [WD_W-1:0] wd_cnt;

    logic if_cand;
    logic ls_cand;
    logic grant_if;
    logic grant_ls;
    logic abort_busy;

    // Grant decision. A flush removes fetches and loads from contention but
    // stores are architectural and may still go out. When both sides compete,
    // LS wins until IF has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        if_cand  = if_ena && !drop_flag;
        ls_cand  = ls_ena && (ls_wr || !drop_flag);
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == IDLE) begin
            if (if_cand && ls_cand) begin
                if (starve_cnt == 4'(STARVE_LIMIT)) begin
                    grant_if = 1'b1;
                end else begin
                    grant_ls = 1'b1;
                end
            end else begin
                grant_if = if_cand;
                grant_ls = ls_cand;
            end
        end
    end

    // A flush aborts a busy fetch or load, but an issued store must finish.
    always_comb begin
        abort_busy = 1'b0;
        if (drop_flag) begin
            abort_busy = (state == BUSY_IF) || ((state == BUSY_LS) && !mc_wr);
        end
    end

    // Main FSM with registered outputs. Pulse outputs default low every
    // ready cycle; nothing moves while rdy is low. The abort path takes
    // priority over a same-cycle mc_ok so a flushed access never completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            wd_cnt      <= '0;
            if_ok       <= 1'b0;
            if_inst     <= '0;
            ls_ok       <= 1'b0;
            ls_rdata    <= '0;
            mc_ena      <= 1'b0;
            mc_wr       <= 1'b0;
            mc_size     <= '0;
            mc_addr     <= '0;
            mc_wdata    <= '0;
            mc_drop     <= 1'b0;
            err_timeout <= 1'b0;
        end else if (rdy) begin
            mc_ena   <= 1'b0;
            mc_drop  <= 1'b0;
            if_ok    <= 1'b0;
            if_inst  <= '0;
            ls_ok    <= 1'b0;
            ls_rdata <= '0;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (grant_if) begin
                        state      <= BUSY_IF;
                        mc_ena     <= 1'b1;
                        mc_wr      <= 1'b0;
                        mc_size    <= 3'd4;
                        mc_addr    <= if_pc;
                        mc_wdata   <= '0;
                        starve_cnt <= '0;
                    end else if (grant_ls) begin
                        state    <= BUSY_LS;
                        mc_ena   <= 1'b1;
                        mc_wr    <= ls_wr;
                        mc_size  <= ls_size;
                        mc_addr  <= ls_addr;
                        mc_wdata <= ls_wdata;
                        if (if_ena && (starve_cnt != 4'(STARVE_LIMIT))) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                BUSY_IF, BUSY_LS: begin
                    // Watchdog saturates at TIMEOUT; the flag is raised on the
                    // same edge the count reaches it and is only cleared by reset.
                    if (wd_cnt != WD_W'(TIMEOUT)) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                    if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                    end
                    if (abort_busy) begin
                        state   <= IDLE;
                        mc_drop <= 1'b1;
                    end else if (mc_ok) begin
                        state <= IDLE;
                        if (state == BUSY_IF) begin
                            if_ok   <= 1'b1;
                            if_inst <= mc_rdata;
                        end else begin
                            ls_ok    <= 1'b1;
                            ls_rdata <= mc_wr ? 32'd0 : mc_rdata;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed and randomized checks of mem_port_arbiter. The bench acts as both
// requesters and as the memory controller. A transaction-level model predicts
// which requester owns each issue from the arbitration rules and tracks the
// fetch-starvation count.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        drop_flag = 1'b0;
    logic        if_ena = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_ok;
    logic [31:0] if_inst;
    logic        ls_ena = 1'b0;
    logic        ls_wr = 1'b0;
    logic [2:0]  ls_size = '0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_ok;
    logic [31:0] ls_rdata;
    logic        mc_ena;
    logic        mc_wr;
    logic [2:0]  mc_size;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic        mc_drop;
    logic        mc_ok = 1'b0;
    logic [31:0] mc_rdata = '0;
    logic        err_timeout;

    int total_checks  = 0;
    int passed_checks = 0;
    int failed_checks = 0;
    int model_starve  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .drop_flag  (drop_flag),
        .if_ena     (if_ena),
        .if_pc      (if_pc),
        .if_ok      (if_ok),
        .if_inst    (if_inst),
        .ls_ena     (ls_ena),
        .ls_wr      (ls_wr),
        .ls_size    (ls_size),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_ok      (ls_ok),
        .ls_rdata   (ls_rdata),
        .mc_ena     (mc_ena),
        .mc_wr      (mc_wr),
        .mc_size    (mc_size),
        .mc_addr    (mc_addr),
        .mc_wdata   (mc_wdata),
        .mc_drop    (mc_drop),
        .mc_ok      (mc_ok),
        .mc_rdata   (mc_rdata),
        .err_timeout(err_timeout)
    );

    // One comparison: counts it, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else begin
            failed_checks++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Arbitration model: 0 = nothing, 1 = fetch, 2 = load/store.
    function automatic int modelWinner(input bit fetch_req, input bit ls_req,
                                       input bit ls_store, input bit flush,
                                       input int starve);
        bit fetch_can;
        bit ls_can;
        fetch_can = fetch_req && !flush;
        ls_can    = ls_req && (ls_store || !flush);
        if (fetch_can && ls_can) return (starve >= STARVE_LIMIT) ? 1 : 2;
        if (fetch_can) return 1;
        if (ls_can) return 2;
        return 0;
    endfunction

    function automatic void modelGrant(input int winner, input bit fetch_waiting);
        if (winner == 1) begin
            model_starve = 0;
        end else if (winner == 2 && fetch_waiting) begin
            model_starve = (model_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : model_starve + 1;
        end
    endfunction

    // Raises any requested side that is not already pending, with random fields.
    task automatic applyStimulus(input bit want_if, input bit want_ls, input bit store);
        if (want_if && !if_ena) begin
            if_ena = 1'b1;
            if_pc  = $urandom & 32'hFFFF_FFFC;
        end
        if (want_ls && !ls_ena) begin
            ls_ena   = 1'b1;
            ls_wr    = store;
            ls_addr  = $urandom;
            ls_wdata = $urandom;
            case ($urandom_range(0, 2))
                0:       ls_size = 3'd1;
                1:       ls_size = 3'd2;
                default: ls_size = 3'd4;
            endcase
        end
    endtask

    // Expects an issue one cycle after the current requests, answers it after
    // resp_delay quiet busy cycles and checks the routed completion.
    task automatic runTransaction(input string tag, input int resp_delay,
                                  input logic [31:0] rdata);
        int          winner;
        logic        exp_wr;
        logic [2:0]  exp_size;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        winner = modelWinner(if_ena, ls_ena, ls_wr, drop_flag, model_starve);
        modelGrant(winner, if_ena);
        if (winner == 1) begin
            exp_wr = 1'b0; exp_size = 3'd4; exp_addr = if_pc; exp_wdata = '0;
        end else begin
            exp_wr = ls_wr; exp_size = ls_size; exp_addr = ls_addr; exp_wdata = ls_wdata;
        end
        tick();
        checkOutput({tag, " mc_ena"}, mc_ena, 1);
        checkOutput({tag, " mc_addr"}, mc_addr, exp_addr);
        checkOutput({tag, " mc_wr"}, mc_wr, exp_wr);
        checkOutput({tag, " mc_size"}, mc_size, exp_size);
        checkOutput({tag, " mc_wdata"}, mc_wdata, exp_wdata);
        checkOutput({tag, " if_ok idle"}, if_ok, 0);
        checkOutput({tag, " ls_ok idle"}, ls_ok, 0);
        checkOutput({tag, " if_inst idle"}, if_inst, 0);
        checkOutput({tag, " ls_rdata idle"}, ls_rdata, 0);
        for (int i = 0; i < resp_delay; i++) begin
            tick();
            checkOutput({tag, " mc_ena busy"}, mc_ena, 0);
            checkOutput({tag, " mc_addr busy"}, mc_addr, exp_addr);
        end
        mc_ok    = 1'b1;
        mc_rdata = rdata;
        tick();
        mc_ok    = 1'b0;
        mc_rdata = '0;
        checkOutput({tag, " mc_drop"}, mc_drop, 0);
        if (winner == 1) begin
            checkOutput({tag, " if_ok"}, if_ok, 1);
            checkOutput({tag, " if_inst"}, if_inst, rdata);
            checkOutput({tag, " ls_ok other"}, ls_ok, 0);
            if_ena = 1'b0;
        end else begin
            checkOutput({tag, " ls_ok"}, ls_ok, 1);
            checkOutput({tag, " ls_rdata"}, ls_rdata, exp_wr ? 32'd0 : rdata);
            checkOutput({tag, " if_ok other"}, if_ok, 0);
            ls_ena = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] data;

        // Reset state
        rdy = 1'b1;
        tick();
        tick();
        checkOutput("reset mc_ena", mc_ena, 0);
        checkOutput("reset if_ok", if_ok, 0);
        checkOutput("reset ls_ok", ls_ok, 0);
        checkOutput("reset mc_drop", mc_drop, 0);
        checkOutput("reset mc_addr", mc_addr, 0);
        checkOutput("reset err", err_timeout, 0);
        rst = 1'b1;
        tick();

        // Single fetch, controller answers five cycles after the issue
        if_ena = 1'b1;
        if_pc  = 32'h0000_0100;
        runTransaction("single fetch", 4, 32'h0000_0513);

        // Simultaneous requests: load goes first, fetch follows
        if_ena = 1'b1; if_pc = 32'h0000_0200;
        ls_ena = 1'b1; ls_wr = 1'b0; ls_size = 3'd4; ls_addr = 32'h0000_2000; ls_wdata = '0;
        runTransaction("simul ls", 1, $urandom);
        runTransaction("simul if", 2, $urandom);

        // Starvation: fetch held while LS keeps requesting
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)));
            runTransaction($sformatf("starve %0d", i), $urandom_range(0, 2), $urandom);
        end
        if_ena = 1'b0;
        ls_ena = 1'b0;
        tick();

        // Random traffic
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            if (!if_ena && !ls_ena) applyStimulus(1'b1, 1'b0, 1'b0);
            runTransaction($sformatf("rand %0d", i), $urandom_range(0, 3), $urandom);
        end
        if_ena = 1'b0;
        ls_ena = 1'b0;
        tick();

        // Drop during a load, same cycle as mc_ok
        ls_ena = 1'b1; ls_wr = 1'b0; ls_size = 3'd2; ls_addr = $urandom;
        modelGrant(2, 1'b0);
        tick();
        checkOutput("drop load mc_ena", mc_ena, 1);
        drop_flag = 1'b1; mc_ok = 1'b1; mc_rdata = $urandom; ls_ena = 1'b0;
        tick();
        drop_flag = 1'b0; mc_ok = 1'b0; mc_rdata = '0;
        checkOutput("drop load mc_drop", mc_drop, 1);
        checkOutput("drop load ls_ok", ls_ok, 0);
        tick();
        checkOutput("drop load mc_drop clear", mc_drop, 0);
        checkOutput("drop load ls_ok later", ls_ok, 0);
        checkOutput("drop load no reissue", mc_ena, 0);

        // Drop during a store: store completes
        ls_ena = 1'b1; ls_wr = 1'b1; ls_size = 3'd4; ls_addr = 32'h0003_0000; ls_wdata = $urandom;
        modelGrant(2, 1'b0);
        tick();
        checkOutput("drop store mc_ena", mc_ena, 1);
        checkOutput("drop store mc_wr", mc_wr, 1);
        checkOutput("drop store mc_addr", mc_addr, 32'h0003_0000);
        drop_flag = 1'b1;
        tick();
        drop_flag = 1'b0;
        checkOutput("drop store mc_drop", mc_drop, 0);
        mc_ok = 1'b1; mc_rdata = 32'hDEAD_BEEF;
        tick();
        mc_ok = 1'b0; mc_rdata = '0;
        checkOutput("drop store ls_ok", ls_ok, 1);
        checkOutput("drop store ls_rdata", ls_rdata, 0);
        checkOutput("drop store mc_drop late", mc_drop, 0);
        ls_ena = 1'b0;

        // Drop in IDLE cancels fetch and load grants, but a store still goes
        if_ena = 1'b1; if_pc = 32'h0000_0400;
        ls_ena = 1'b1; ls_wr = 1'b0; ls_size = 3'd1; ls_addr = 32'h0000_5001;
        drop_flag = 1'b1;
        tick();
        checkOutput("idle drop blocks", mc_ena, 0);
        checkOutput("idle drop no mc_drop", mc_drop, 0);
        ls_wr = 1'b1; ls_wdata = $urandom;
        runTransaction("idle drop store", 1, $urandom);
        drop_flag = 1'b0;
        runTransaction("after drop fetch", 0, $urandom);

        // rdy=0 freezes outputs and ignores mc_ok
        if_ena = 1'b1; if_pc = 32'h0000_0800;
        modelGrant(1, 1'b1);
        tick();
        checkOutput("freeze issue", mc_ena, 1);
        rdy = 1'b0; mc_ok = 1'b1; data = $urandom; mc_rdata = data;
        tick();
        checkOutput("freeze mc_ena held", mc_ena, 1);
        checkOutput("freeze if_ok", if_ok, 0);
        rdy = 1'b1; mc_ok = 1'b0;
        tick();
        checkOutput("freeze release mc_ena", mc_ena, 0);
        checkOutput("freeze release if_ok", if_ok, 0);
        mc_ok = 1'b1;
        tick();
        mc_ok = 1'b0; mc_rdata = '0;
        checkOutput("freeze complete if_ok", if_ok, 1);
        checkOutput("freeze complete if_inst", if_inst, data);
        if_ena = 1'b0;

        // Watchdog: controller never answers
        if_ena = 1'b1; if_pc = 32'h0000_0C00;
        modelGrant(1, 1'b1);
        tick();
        checkOutput("wd issue", mc_ena, 1);
        checkOutput("wd err start", err_timeout, 0);
        repeat (TIMEOUT - 1) tick();
        checkOutput("wd err before", err_timeout, 0);
        tick();
        checkOutput("wd err set", err_timeout, 1);
        repeat (5) tick();
        checkOutput("wd err sticky", err_timeout, 1);
        checkOutput("wd mc_addr held", mc_addr, 32'h0000_0C00);
        checkOutput("wd no reissue", mc_ena, 0);

        // Asynchronous reset in the middle of a busy transaction
        #2 rst = 1'b0;
        #1;
        checkOutput("async rst err", err_timeout, 0);
        checkOutput("async rst mc_addr", mc_addr, 0);
        checkOutput("async rst mc_size", mc_size, 0);
        checkOutput("async rst if_ok", if_ok, 0);
        if_ena = 1'b0;
        model_starve = 0;
        tick();
        rst = 1'b1;
        tick();
        if_ena = 1'b1; if_pc = 32'h0000_1000;
        runTransaction("post reset fetch", 1, $urandom);
        checkOutput("post reset err", err_timeout, 0);

        tick();
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits between the instruction fetcher / load-store executor and the single-transaction memory controller port.
- Accepts level-held requests from both sides and issues exactly one downstream transaction at a time.
- Routes the completion pulse and data back to the owner of the transaction.
- Handles flush (drop) of speculative fetches and loads, and bounds fetch starvation behind back-to-back load/store traffic.

Parameters:
- STARVE_LIMIT, 4: consecutive LS grants allowed while IF is waiting before IF is forced next (range 1-15).
- TIMEOUT, 64: cycles a transaction may stay outstanding before err_timeout is raised.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- rdy  input  1  global ready; 0 freezes all state, outputs hold.
- drop_flag  input  1  flush: abort fetch and load activity.
- if_ena  input  1  fetch request, held until if_ok.
- if_pc  input  32  fetch address.
- if_ok  output  1  one-cycle completion pulse.
- if_inst  output  32  instruction; valid while if_ok=1.
- ls_ena  input  1  load/store request, held until ls_ok.
- ls_wr  input  1  1=store, 0=load.
- ls_size  input  3  bytes: 1, 2 or 4.
- ls_addr  input  32  load/store address.
- ls_wdata  input  32  store data.
- ls_ok  output  1  one-cycle completion pulse.
- ls_rdata  output  32  load data; valid while ls_ok=1.
- mc_ena  output  1  one-cycle issue pulse to the memory controller.
- mc_wr, mc_size, mc_addr, mc_wdata  output  1/3/32/32  issued command; held stable while busy.
- mc_drop  output  1  one-cycle abort pulse to the controller.
- mc_ok  input  1  controller completion pulse.
- mc_rdata  input  32  controller read data.
- err_timeout  output  1  sticky watchdog flag.

Behaviour:
Reset (rst=0, async):
- State=IDLE; starve_cnt=0; wd_cnt=0.
- All outputs 0.

rdy=0:
- No state or counter changes; outputs hold.

States:
- IDLE --grant--> BUSY_IF or BUSY_LS.
- BUSY_* --mc_ok--> IDLE.
- BUSY_IF or BUSY_LS(load) --drop_flag--> IDLE.

Grant rule (evaluated in IDLE only):
- ls_ena && if_ena: LS wins unless starve_cnt==STARVE_LIMIT, in which case IF wins.
- Single requester: that requester wins.
- Grant cycle: latch the command into the mc_* registers and pulse mc_ena in the following cycle. Issue latency is 1 cycle from request seen in IDLE.
- On LS grant while if_ena=1: starve_cnt+1 (saturating).
- On any IF grant: starve_cnt=0.
- No grant is made while drop_flag=1: fetches and loads are blocked. Stores may still be granted.
- The state returns to IDLE in the cycle mc_ok is seen. A new grant is possible in the following cycle, so there is a minimum 1-cycle gap between transactions.

Completion:
- mc_ok in BUSY_IF: if_ok=1 and if_inst=mc_rdata next cycle.
- mc_ok in BUSY_LS: ls_ok=1 and ls_rdata=mc_rdata (rdata 0 for stores) next cycle.
- ok pulses last exactly 1 cycle. Data outputs return to 0 when ok deasserts.

Drop:
- BUSY_IF or BUSY_LS(load): mc_drop=1 for 1 cycle, state goes to IDLE, and no ok is issued even if mc_ok arrives in the same cycle.
- BUSY_LS(store): no effect; the store completes normally and ls_ok is delivered.
- Drop in IDLE: no action.
- A drop in the same cycle as a requester's request cancels that candidate grant (fetches and loads only).

Watchdog:
- wd_cnt counts cycles spent in BUSY_* and clears in IDLE.
- At wd_cnt==TIMEOUT, err_timeout is set and remains 1 until reset. State is unchanged.

Protocol assertions:
- mc_ena never fires while BUSY.
- Never more than one transaction outstanding.
- The mc_* command registers are unchanged while BUSY.

Test Plan:
- Single fetch: if_ena=1, if_pc=0x100; mc_ok 5 cycles after mc_ena with mc_rdata=0x00000513 -> mc_addr=0x100, mc_wr=0, mc_size=4; if_ok pulses once with if_inst=0x00000513.
- Simultaneous requests: if_ena=1 and ls_ena=1 (load, addr 0x2000, size 4) in the same cycle -> LS issued first; IF issued after ls_ok; starve_cnt=1.
- Starvation: if_ena held 1, ls_ena held 1 with STARVE_LIMIT=4 -> 4 LS grants, then an IF grant, then LS again; starve_cnt returns to 0 after the IF grant.
- Drop during load: BUSY_LS load, drop_flag=1 in the same cycle as mc_ok -> mc_drop pulses, no ls_ok, state IDLE.
- Drop during store: store to 0x30000 with drop_flag=1 mid-transaction -> no mc_drop; ls_ok delivered on mc_ok.
- Timeout and reset: mc_ok never returns -> err_timeout=1 at cycle 64 and stays set. rst=0 mid-BUSY -> all outputs 0 immediately, state IDLE, err_timeout cleared.
